// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the character sequencer slice.
package seg_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } seq_state_t;

  localparam int          CHAR_W_DEF = 7;
  localparam logic [6:0]  BLANK_CHAR = 7'h00;
  localparam int          HOLD_CNT_W = 8;

endpackage

// File: rtl/seg_char_fifo.sv
// Synchronous FIFO with registered pointers and an explicit occupancy count.
module seg_char_fifo #(
  parameter int DEPTH  = 4,
  parameter int CHAR_W = 7,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [CHAR_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop,
  output logic [CHAR_W-1:0] head,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][CHAR_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [LVL_W-1:0]             count;
  logic                         push, pop_ok;

  assign push_ready = (count != LVL_W'(DEPTH));
  assign push       = push_valid && push_ready;
  assign pop_ok     = pop && (count != '0);
  assign head       = mem[rd_ptr];
  assign level      = count;

  // Storage needs no reset; only the occupancy bookkeeping does.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seg_char_sequencer.sv
// Character scheduler ahead of the segment animator: queue, strobe one char,
// wait for its animation, hold the glyph HOLD_TICKS frames, repeat.
// Build option: SEQ_REPEAT_EN loops the last glyph while the queue is empty.
module seg_char_sequencer
  import seg_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int HOLD_TICKS = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       tick60,
  input  logic                       in_valid,
  input  logic [CHAR_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       anim_busy,
  output logic                       out_valid,
  output logic [CHAR_W-1:0]          out_char,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       idle
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_TICKS - 1);

  seq_state_t            state;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [CHAR_W-1:0]     head;
  logic                  pop;
  logic                  q_empty;

  assign q_empty = (level == '0);
  // An ISSUE with an empty queue is a repeat: re-strobe without popping.
  assign pop     = ena && (state == S_ISSUE) && !q_empty;
  assign idle    = (state == S_IDLE) && q_empty;

  seg_char_fifo #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_data  (in_data),
    .push_ready (in_ready),
    .pop        (pop),
    .head       (head),
    .level      (level)
  );

  // Sequencer FSM; ena low freezes state and counter and suppresses the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      out_valid <= 1'b0;
      out_char  <= CHAR_W'(BLANK_CHAR);
    end else begin
      out_valid <= 1'b0;
      if (ena) begin
        unique case (state)
          S_IDLE: begin
            if (!q_empty) state <= S_ISSUE;
          end
          S_ISSUE: begin
            out_valid <= 1'b1;
            if (!q_empty) out_char <= head;
            state <= S_GUARD;
          end
          // Animator raises busy a cycle after the strobe; skip that cycle.
          S_GUARD: state <= S_WAIT;
          S_WAIT: begin
            if (!anim_busy) begin
              hold_cnt <= '0;
              state    <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (tick60) begin
              if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
`ifdef SEQ_REPEAT_EN
                state    <= S_ISSUE;
`else
                state    <= S_IDLE;
`endif
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_char_sequencer.sv
// Directed bench for seg_char_sequencer (DEPTH=4, HOLD_TICKS=3).
module tb_seg_char_sequencer;

  localparam int DEPTH  = 4;
  localparam int CHAR_W = 7;
  localparam int HT     = 3;

  logic              clk = 1'b0;
  logic              rst_n, ena, tick60, in_valid, anim_busy;
  logic [CHAR_W-1:0] in_data;
  logic              in_ready, out_valid, idle;
  logic [CHAR_W-1:0] out_char;
  logic [2:0]        level;

  int nchk = 0;
  int nerr = 0;

`ifdef SEQ_REPEAT_EN
  localparam logic IDLE_AFTER = 1'b0;
`else
  localparam logic IDLE_AFTER = 1'b1;
`endif

  seg_char_sequencer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W), .HOLD_TICKS(HT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tick60    (tick60),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .anim_busy (anim_busy),
    .out_valid (out_valid),
    .out_char  (out_char),
    .level     (level),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; tick60 = 1'b0; in_valid = 1'b0;
    in_data = '0; anim_busy = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input string tag, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step();
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int acc;
    int nstr;

    // Reset state
    do_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);

    // Single char: strobe 2 cycles after push, idle after HT ticks in HOLD
    in_valid = 1'b1; in_data = 7'h0A;
    step();
    in_valid = 1'b0;
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_idle_busy", 32'(idle), 32'd0);
    step();
    chk("t1_no_early", 32'(out_valid), 32'd0);
    step();
    chk("t1_strobe", 32'(out_valid), 32'd1);
    chk("t1_char", 32'(out_char), 32'h0A);
    chk("t1_popped", 32'(level), 32'd0);
    step();
    chk("t1_one_shot", 32'(out_valid), 32'd0);
    step();
    for (int k = 0; k < HT; k++) begin
      tick60 = 1'b1; step();
      tick60 = 1'b0; step();
      if (k < HT - 1) chk("t1_holding", 32'(idle), 32'd0);
    end
    chk("t1_idle_end", 32'(idle), 32'(IDLE_AFTER));
`ifdef SEQ_REPEAT_EN
    chk("t1_repeat", 32'(out_valid), 32'd1);
    chk("t1_repeat_char", 32'(out_char), 32'h0A);
`endif

    // Long busy: no second strobe, ticks ignored until busy falls; entry tick not counted
    do_reset();
    anim_busy = 1'b1;
    in_valid = 1'b1; in_data = 7'h11;
    step();
    in_valid = 1'b0;
    wait_strobe("t3_strobe", 5);
    chk("t3_char", 32'(out_char), 32'h11);
    nstr = 0;
    for (int i = 0; i < 100; i++) begin
      tick60 = (i % 10 == 0);
      step();
      if (out_valid) nstr++;
    end
    tick60 = 1'b0;
    chk("t3_no_restrobe", 32'(nstr), 32'd0);
    chk("t3_not_idle", 32'(idle), 32'd0);
    anim_busy = 1'b0; tick60 = 1'b1;
    step();
    step();
    step();
    chk("t3_entry_tick_ignored", 32'(idle), 32'd0);
    step();
    tick60 = 1'b0;
    chk("t3_exit_third_tick", 32'(idle), 32'(IDLE_AFTER));

    // FIFO fill during WAIT_ANIM, 5th char held off until next pop
    do_reset();
    anim_busy = 1'b1;
    in_valid = 1'b1; in_data = 7'h21;
    step();
    in_valid = 1'b0;
    wait_strobe("t2_strobe0", 5);
    step();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 7'(8'h30 + i);
      if (in_ready) acc++;
      step();
    end
    chk("t2_accepts", 32'(acc), 32'd4);
    chk("t2_full_level", 32'(level), 32'd4);
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    anim_busy = 1'b0;
    step();
    tick60 = 1'b1;
    step(); step(); step();
    tick60 = 1'b0;
    chk("t2_level_held", 32'(level), 32'd4);
    wait_strobe("t2_strobe1", 4);
    chk("t2_head_char", 32'(out_char), 32'h30);
    chk("t2_pop_level", 32'(level), 32'd3);
    chk("t2_ready_again", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t2_fifth_in", 32'(level), 32'd4);

    // Reset mid-HOLD with a non-empty queue
    step();
    step();
    chk("t6_pre_level", 32'(level), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_char", 32'(out_char), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // ena low defers the issue; push still accepted
    ena = 1'b0;
    in_valid = 1'b1; in_data = 7'h55;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_frozen", 32'(out_valid), 32'd0);
    end
    chk("t5_level", 32'(level), 32'd1);
    chk("t5_not_idle", 32'(idle), 32'd0);
    ena = 1'b1;
    step();
    chk("t5_issue_entry", 32'(out_valid), 32'd0);
    step();
    chk("t5_strobe", 32'(out_valid), 32'd1);
    chk("t5_char", 32'(out_char), 32'h55);
    chk("t5_popped", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
